// File: rtl/scene_pkg.sv
// scene_pkg: shared definitions for the end-scene overlay logic.
//   - FSM state encoding of end_scene_ctrl (codes 5-7 unused)
//   - banner geometry (width, height, rest row) in pixels
//   - screen coordinate width
//   - saturating banner-row adder used by the slide animation
package scene_pkg;

  localparam int COORD_W       = 10;
  localparam int BANNER_W      = 800;
  localparam int BANNER_H      = 165;
  localparam int BANNER_REST_Y = 216;

  typedef enum logic [2:0] {
    ST_PLAY     = 3'd0,
    ST_DELAY    = 3'd1,
    ST_SLIDE    = 3'd2,
    ST_WAIT_KEY = 3'd3,
    ST_RESTART  = 3'd4
  } state_e;

  // Add one slide step to the banner row and clamp at the rest row.
  // The sum carries one extra bit so a large step can never wrap past 1023.
  function automatic logic [COORD_W-1:0] sat_add(
    input logic [COORD_W-1:0] y,
    input logic [COORD_W-1:0] step,
    input logic [COORD_W-1:0] lim
  );
    logic [COORD_W:0] sum;
    sum = {1'b0, y} + {1'b0, step};
    if (sum >= {1'b0, lim}) begin
      sat_add = lim;
    end else begin
      sat_add = sum[COORD_W-1:0];
    end
  endfunction

endpackage

// File: rtl/end_scene_ctrl_key_edge.sv
// key_edge: registers a level input and flags its rising edge.
// Ports:
//   clk     in   system clock
//   rst     in   synchronous active-high reset
//   i_key   in   level input (already debounced)
//   o_level out  registered sample of i_key
//   o_rise  out  high for one cycle when the registered sample goes 0 -> 1
module key_edge (
  input  logic clk,
  input  logic rst,
  input  logic i_key,
  output logic o_level,
  output logic o_rise
);

  logic r_cur;
  logic r_prev;

  // Current and previous samples of the key.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur  <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_cur  <= i_key;
      r_prev <= r_cur;
    end
  end

  assign o_level = r_cur;
  assign o_rise  = r_cur & ~r_prev;

endmodule

// File: rtl/end_scene_ctrl.sv
// end_scene_ctrl: game-over sequencer for the end-scene overlay.
// On player death it freezes gameplay, waits DELAY_FRAMES frames, slides the
// banner down to FINAL_Y by SLIDE_STEP rows per frame, then waits for a fresh
// restart key press and emits a one-cycle restart pulse.
// Optional feature macro: END_BLINK_EN (banner blinks every BLINK_FRAMES
// frames while waiting for the key).
// All inputs pass through one sample register before the FSM acts on them.
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   frame_tick   in   one-cycle pulse per video frame
//   player_dead  in   level, player has died (only looked at in PLAY)
//   restart_key  in   level, debounced restart key
//   freeze       out  halts game physics and input
//   show_overlay out  enables end-scene compositing
//   overlay_y    out  banner top row
//   restart      out  one-cycle game world reset pulse
//   state        out  current FSM state (debug)
module end_scene_ctrl
  import scene_pkg::*;
#(
  parameter int unsigned DELAY_FRAMES = 30,
  parameter int unsigned FINAL_Y      = BANNER_REST_Y,
  parameter int unsigned SLIDE_STEP   = 8,
  parameter int unsigned BLINK_FRAMES = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_tick,
  input  logic               player_dead,
  input  logic               restart_key,
  output logic               freeze,
  output logic               show_overlay,
  output logic [COORD_W-1:0] overlay_y,
  output logic               restart,
  output logic [2:0]         state
);

  localparam logic [15:0]        L_DELAY = 16'(DELAY_FRAMES);
  localparam logic [COORD_W-1:0] L_FINAL = COORD_W'(FINAL_Y);
  localparam logic [COORD_W-1:0] L_STEP  = COORD_W'(SLIDE_STEP);

  state_e             r_state;
  state_e             w_state_nxt;
  logic               r_dead;
  logic               r_tick;
  logic [15:0]        r_cnt;
  logic [15:0]        w_cnt_nxt;
  logic [15:0]        w_cnt_inc;
  logic               r_armed;
  logic               w_armed_nxt;
  logic [COORD_W-1:0] r_y;
  logic [COORD_W-1:0] w_y_nxt;
  logic [COORD_W-1:0] w_y_sat;
  logic               r_freeze;
  logic               r_show;
  logic               w_show_nxt;
  logic               r_restart;
  logic               w_key_level;
  logic               w_key_rise;

  key_edge u_key_edge (
    .clk     (clk),
    .rst     (rst),
    .i_key   (restart_key),
    .o_level (w_key_level),
    .o_rise  (w_key_rise)
  );

  assign w_cnt_inc = r_cnt + 16'd1;
  assign w_y_sat   = sat_add(r_y, L_STEP, L_FINAL);

  // Input sample registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_dead <= 1'b0;
      r_tick <= 1'b0;
    end else begin
      r_dead <= player_dead;
      r_tick <= frame_tick;
    end
  end

  // Next state, frame counter, armed flag and banner row.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_armed_nxt = r_armed;
    w_y_nxt     = r_y;
    case (r_state)
      ST_PLAY: begin
        if (r_dead) begin
          w_state_nxt = ST_DELAY;
          w_cnt_nxt   = 16'd0;
        end else begin
          w_state_nxt = ST_PLAY;
        end
      end
      ST_DELAY: begin
        // Zero delay leaves after one cycle without needing a tick.
        if (L_DELAY == 16'd0) begin
          w_state_nxt = ST_SLIDE;
          w_y_nxt     = {COORD_W{1'b0}};
        end else if (r_tick) begin
          w_cnt_nxt = w_cnt_inc;
          if (w_cnt_inc == L_DELAY) begin
            w_state_nxt = ST_SLIDE;
            w_y_nxt     = {COORD_W{1'b0}};
          end else begin
            w_state_nxt = ST_DELAY;
          end
        end else begin
          w_state_nxt = ST_DELAY;
        end
      end
      ST_SLIDE: begin
        if (r_tick) begin
          w_y_nxt = w_y_sat;
          if (w_y_sat == L_FINAL) begin
            w_state_nxt = ST_WAIT_KEY;
            w_armed_nxt = 1'b0;
          end else begin
            w_state_nxt = ST_SLIDE;
          end
        end else begin
          w_state_nxt = ST_SLIDE;
        end
      end
      ST_WAIT_KEY: begin
        // Only a press that follows an observed release counts.
        if (w_key_rise && r_armed) begin
          w_state_nxt = ST_RESTART;
          w_y_nxt     = {COORD_W{1'b0}};
        end else if (!w_key_level) begin
          w_armed_nxt = 1'b1;
        end else begin
          w_armed_nxt = r_armed;
        end
      end
      ST_RESTART: begin
        w_state_nxt = ST_PLAY;
        w_y_nxt     = {COORD_W{1'b0}};
      end
      default: begin
        w_state_nxt = ST_PLAY;
        w_y_nxt     = {COORD_W{1'b0}};
      end
    endcase
  end

`ifdef END_BLINK_EN
  localparam logic [15:0] L_BLINK = 16'(BLINK_FRAMES);

  logic [15:0] r_blink_cnt;
  logic [15:0] w_blink_cnt_nxt;
  logic        r_vis;
  logic        w_vis_nxt;

  // Blink phase: restarts visible on entry to WAIT_KEY, toggles every L_BLINK ticks.
  always_comb begin
    w_blink_cnt_nxt = r_blink_cnt;
    w_vis_nxt       = r_vis;
    if ((r_state != ST_WAIT_KEY) && (w_state_nxt == ST_WAIT_KEY)) begin
      w_blink_cnt_nxt = 16'd0;
      w_vis_nxt       = 1'b1;
    end else if ((r_state == ST_WAIT_KEY) && r_tick) begin
      if ((r_blink_cnt + 16'd1) == L_BLINK) begin
        w_blink_cnt_nxt = 16'd0;
        w_vis_nxt       = ~r_vis;
      end else begin
        w_blink_cnt_nxt = r_blink_cnt + 16'd1;
      end
    end else begin
      w_blink_cnt_nxt = r_blink_cnt;
    end
    w_show_nxt = (w_state_nxt == ST_SLIDE) ||
                 ((w_state_nxt == ST_WAIT_KEY) && w_vis_nxt);
  end

  // Blink phase registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_blink_cnt <= 16'd0;
      r_vis       <= 1'b1;
    end else begin
      r_blink_cnt <= w_blink_cnt_nxt;
      r_vis       <= w_vis_nxt;
    end
  end
`else
  assign w_show_nxt = (w_state_nxt == ST_SLIDE) || (w_state_nxt == ST_WAIT_KEY);
`endif

  // FSM state and registered outputs, all derived from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_PLAY;
      r_cnt     <= 16'd0;
      r_armed   <= 1'b0;
      r_y       <= {COORD_W{1'b0}};
      r_freeze  <= 1'b0;
      r_show    <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_armed   <= w_armed_nxt;
      r_y       <= w_y_nxt;
      r_freeze  <= (w_state_nxt == ST_DELAY) || (w_state_nxt == ST_SLIDE) ||
                   (w_state_nxt == ST_WAIT_KEY);
      r_show    <= w_show_nxt;
      r_restart <= (w_state_nxt == ST_RESTART);
    end
  end

  assign freeze       = r_freeze;
  assign show_overlay = r_show;
  assign overlay_y    = r_y;
  assign restart      = r_restart;
  assign state        = r_state;

endmodule
